// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - oversampled SPI mode-0 slave capturing one csel-framed transfer into a held frame register
// Echoes each received byte on miso one byte slot later, with STATUS_BYTE in the first slot.
module spi_frame_rx #(
  parameter int         FRAME_BYTES = 4,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk,
  input  logic                     mosi,
  input  logic                     csel,
  output logic                     miso,
  output logic [FRAME_BYTES*8-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int FW  = FRAME_BYTES * 8;
  localparam int BCW = $clog2(FRAME_BYTES + 2);
  localparam logic [BCW-1:0] BC_FULL = BCW'(FRAME_BYTES);
  localparam logic [BCW-1:0] BC_MAX  = BCW'(FRAME_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_next;

  logic sclk_s1, sclk_s2, sclk_h;
  logic mosi_s1, mosi_s2;
  logic csel_s1, csel_s2, csel_h;

  logic [2:0]     bit_cnt;
  logic [BCW-1:0] byte_cnt;
  logic [7:0]     cur_byte;
  logic [7:0]     rx_byte;
  logic [7:0]     miso_sr;
  logic           miso_q;
  logic [FW-1:0]  staging;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, commit_ok;

  // History FFs reset low, so csel must be seen high before a falling edge can register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_h <= 1'b0;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
      csel_s1 <= 1'b0; csel_s2 <= 1'b0; csel_h <= 1'b0;
    end else begin
      sclk_s1 <= sclk;    sclk_s2 <= sclk_s1; sclk_h <= sclk_s2;
      mosi_s1 <= mosi;    mosi_s2 <= mosi_s1;
      csel_s1 <= csel;    csel_s2 <= csel_s1; csel_h <= csel_s2;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_h;
  assign sclk_fall = ~sclk_s2 & sclk_h;
  assign cs_fall   = ~csel_s2 & csel_h;
  assign cs_rise   = csel_s2 & ~csel_h;
  assign commit_ok = (byte_cnt == BC_FULL) && (bit_cnt == 3'd0);
  assign rx_byte   = {mosi_s2, cur_byte[6:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = RECV;
      RECV:    if (cs_rise) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= 3'd0;
      byte_cnt    <= '0;
      cur_byte    <= 8'd0;
      miso_sr     <= 8'd0;
      miso_q      <= 1'b0;
      staging     <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            cur_byte <= 8'd0;
            // Bit 0 of the status byte must be on the pin before the first sclk rise.
            miso_q   <= STATUS_BYTE[0];
            miso_sr  <= {1'b0, STATUS_BYTE[7:1]};
          end
        end
        RECV: begin
          if (!cs_rise) begin
            if (sclk_rise) begin
              cur_byte[bit_cnt] <= mosi_s2;
              bit_cnt           <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                for (int i = 0; i < FRAME_BYTES; i++)
                  if (byte_cnt == BCW'(i)) staging[FW-8-8*i +: 8] <= rx_byte;
                miso_sr <= rx_byte;
                if (byte_cnt != BC_MAX) byte_cnt <= byte_cnt + 1'b1;
              end
            end else if (sclk_fall) begin
              miso_q  <= miso_sr[0];
              miso_sr <= {1'b0, miso_sr[7:1]};
            end
          end
        end
        COMMIT: begin
          if (commit_ok) begin
            frame_data  <= staging;
            frame_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RECV);
  assign miso = miso_q & busy;

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - self-checking bench for spi_frame_rx
// Frames are bit-banged at sclk = clk/48 and checked against a byte-level model of the frame rules.
module tb_spi_frame_rx;
  localparam int FB = 4;
  localparam int H  = 24;
  localparam logic [7:0] STATUS = 8'hA5;

  logic          clk = 1'b0;
  logic          rst, sclk, mosi, csel;
  logic          miso, frame_valid, frame_err, busy;
  logic [FB*8-1:0] frame_data;

  spi_frame_rx #(.FRAME_BYTES(FB), .STATUS_BYTE(STATUS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .csel(csel), .miso(miso),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_valid = 0, n_err = 0, n_both = 0;
  logic [FB*8-1:0] exp_data = '0;
  logic [7:0] miso_bytes[$];
  logic busy_mid;
  int lat;

  always @(negedge clk) begin
    if (frame_valid) n_valid++;
    if (frame_err) n_err++;
    if (frame_valid && frame_err) n_both++;
  end

  function automatic logic [FB*8-1:0] pack_frame(input logic [7:0] d[$]);
    logic [FB*8-1:0] r;
    r = '0;
    for (int b = 0; b < FB; b++) r = {r[FB*8-9:0], d[b]};
    return r;
  endfunction

  task automatic send_frame(input logic [7:0] d[$], input int nbits, input int rst_at_bit, input int gap);
    logic [7:0] rx, b;
    rx = 8'd0;
    miso_bytes.delete();
    busy_mid = 1'b0;
    @(negedge clk) csel = 1'b0;
    repeat (2*H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at_bit) begin
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
      end
      b = d[i/8];
      mosi = b[i%8];
      repeat (H) @(negedge clk);
      rx[i%8] = miso;
      sclk = 1'b1;
      if (i == 0) busy_mid = busy;
      if (i % 8 == 7) miso_bytes.push_back(rx);
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (H) @(negedge clk);
    csel = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (lat < 0 && (frame_valid || frame_err)) lat = k;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; csel = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (frame_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", frame_data); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", miso); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_good_frame();
    logic [7:0] d[$];
    int v0, e0;
    d = '{8'hde, 8'had, 8'hbe, 8'hef};
    v0 = n_valid; e0 = n_err;
    send_frame(d, 32, -1, 40);
    exp_data = pack_frame(d);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL good_valid_count: got %0d want 1", n_valid - v0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL good_err_count: got %0d want 0", n_err - e0); end
    checks++; if (frame_data !== 32'hdeadbeef) begin errors++; $display("FAIL good_data: got %h want deadbeef", frame_data); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL good_latency: got %0d want 4", lat); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL good_busy_mid: got %b want 1", busy_mid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_after: got %b want 0", busy); end
    for (int j = 0; j < FB; j++) begin
      checks++;
      if (miso_bytes[j] !== ((j == 0) ? STATUS : d[j-1])) begin
        errors++; $display("FAIL miso_echo[%0d]: got %h want %h", j, miso_bytes[j], (j == 0) ? STATUS : d[j-1]);
      end
    end
  endtask

  task automatic test_short_frame();
    logic [7:0] d[$];
    int v0, e0;
    d = '{8'h11, 8'h22, 8'h33};
    v0 = n_valid; e0 = n_err;
    send_frame(d, 24, -1, 40);
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL short_err_count: got %0d want 1", n_err - e0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL short_valid_count: got %0d want 0", n_valid - v0); end
    checks++; if (frame_data !== 32'hdeadbeef) begin errors++; $display("FAIL short_data: got %h want deadbeef", frame_data); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL short_latency: got %0d want 4", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy: got %b want 0", busy); end
  endtask

  task automatic test_oversize();
    logic [7:0] d[$];
    int v0, e0;
    int lens[3];
    lens = '{40, 37, 0};
    d = '{8'h99, 8'h88, 8'h77, 8'h66, 8'h55};
    foreach (lens[k]) begin
      v0 = n_valid; e0 = n_err;
      send_frame(d, lens[k], -1, 40);
      checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL oversize_err[%0d bits]: got %0d want 1", lens[k], n_err - e0); end
      checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL oversize_valid[%0d bits]: got %0d want 0", lens[k], n_valid - v0); end
      checks++; if (frame_data !== exp_data) begin errors++; $display("FAIL oversize_data[%0d bits]: got %h want %h", lens[k], frame_data, exp_data); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1[$], d2[$];
    int v0, e0;
    d1 = '{8'h01, 8'h02, 8'h03, 8'h04};
    d2 = '{8'h05, 8'h06, 8'h07, 8'h08};
    v0 = n_valid; e0 = n_err;
    send_frame(d1, 32, -1, 4*H - 20 - 2*H);
    send_frame(d2, 32, -1, 40);
    exp_data = pack_frame(d2);
    checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d want 2", n_valid - v0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL b2b_err_count: got %0d want 0", n_err - e0); end
    checks++; if (frame_data !== 32'h05060708) begin errors++; $display("FAIL b2b_data: got %h want 05060708", frame_data); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d[$];
    int v0, e0;
    d = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
    v0 = n_valid; e0 = n_err;
    send_frame(d, 32, 16, 40);
    exp_data = '0;
    checks++; if (n_valid - v0 + n_err - e0 !== 0) begin errors++; $display("FAIL rstmid_pulses: got %0d want 0", n_valid - v0 + n_err - e0); end
    checks++; if (frame_data !== exp_data) begin errors++; $display("FAIL rstmid_data: got %h want 0", frame_data); end
    d = '{8'h12, 8'h34, 8'h56, 8'h78};
    v0 = n_valid;
    send_frame(d, 32, -1, 40);
    exp_data = pack_frame(d);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL rstmid_next_valid: got %0d want 1", n_valid - v0); end
    checks++; if (frame_data !== 32'h12345678) begin errors++; $display("FAIL rstmid_next_data: got %h want 12345678", frame_data); end
  endtask

  task automatic test_random();
    logic [7:0] d[$];
    int v0, e0, nbits;
    logic exp_ok;
    for (int it = 0; it < 8; it++) begin
      d.delete();
      for (int b = 0; b < 6; b++) d.push_back(8'($urandom));
      nbits = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 44)) : FB*8;
      exp_ok = (nbits == FB*8);
      v0 = n_valid; e0 = n_err;
      send_frame(d, nbits, -1, 40);
      if (exp_ok) exp_data = pack_frame(d);
      checks++; if (n_valid - v0 !== (exp_ok ? 1 : 0)) begin errors++; $display("FAIL rand_valid[%0d] bits=%0d: got %0d want %0d", it, nbits, n_valid - v0, exp_ok ? 1 : 0); end
      checks++; if (n_err - e0 !== (exp_ok ? 0 : 1)) begin errors++; $display("FAIL rand_err[%0d] bits=%0d: got %0d want %0d", it, nbits, n_err - e0, exp_ok ? 0 : 1); end
      checks++; if (frame_data !== exp_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", it, frame_data, exp_data); end
    end
    checks++; if (n_both !== 0) begin errors++; $display("FAIL valid_err_overlap: got %0d want 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_oversize();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
